// File: rtl/pat_scan_arbiter.sv
// Round-robin owner of one serial 1011 detector: latch a word, clear, stream MSB first, count hits, ack (W+3 cycles).
// Define PAT_SCAN_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module pat_scan_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              match_any,
  output logic              det_clr,
  output logic              ser_valid,
  output logic              ser_bit,
  input  logic              det_hit
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0]    LAST_BIT = BW'(W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [BW-1:0]    idx, idx_n;
  logic [W-1:0]     sh, sh_n, win_dat;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, match_cnt_n;
  logic [NREQ-1:0]  grant_n, ack_n;
  logic             busy_n, match_any_n, det_clr_n, ser_valid_n, ser_bit_n;
  logic             win_vld;
  logic [IW-1:0]    win;

`ifdef PAT_SCAN_FIXED_PRIO_EN
  // Descending scan so the lowest asserted index is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win     = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr, ptr_n;
  logic [IW:0]   rr_idx;

  // Scan offsets from ptr in descending order; the nearest request at or after ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    rr_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rr_idx = {1'b0, ptr} + (IW+1)'(k);
      if (rr_idx >= (IW+1)'(NREQ)) rr_idx = rr_idx - (IW+1)'(NREQ);
      if (req[rr_idx[IW-1:0]]) begin
        win_vld = 1'b1;
        win     = rr_idx[IW-1:0];
      end
    end
  end
`endif

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    sh_n        = sh;
    cnt_n       = cnt;
    grant_n     = grant;
    ack_n       = '0;
    match_cnt_n = match_cnt;
    match_any_n = match_any;
    det_clr_n   = 1'b0;
    ser_valid_n = 1'b0;
    ser_bit_n   = 1'b0;
    win_dat     = '0;
`ifndef PAT_SCAN_FIXED_PRIO_EN
    ptr_n       = ptr;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) win_dat = req_data[i*W +: W];
    end
    cnt_inc = (det_hit && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;

    case (state)
      IDLE: begin
        if (win_vld) begin
          state_n   = CLR;
          grant_n   = NREQ'(1) << win;
          sh_n      = win_dat;
          cnt_n     = '0;
          det_clr_n = 1'b1;
`ifndef PAT_SCAN_FIXED_PRIO_EN
          ptr_n     = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
        end
      end
      CLR: begin
        state_n     = SHIFT;
        idx_n       = '0;
        ser_valid_n = 1'b1;
        ser_bit_n   = sh[W-1];
        sh_n        = sh << 1;
      end
      SHIFT: begin
        // The hit for a bit appears one cycle after it, so the first shift cycle has nothing to sample.
        if (idx != '0) cnt_n = cnt_inc;
        if (idx == LAST_BIT) begin
          state_n = DRAIN;
        end else begin
          idx_n       = idx + 1'b1;
          ser_valid_n = 1'b1;
          ser_bit_n   = sh[W-1];
          sh_n        = sh << 1;
        end
      end
      DRAIN: begin
        state_n     = DONE;
        cnt_n       = cnt_inc;
        match_cnt_n = cnt_inc;
        match_any_n = (cnt_inc != '0);
        ack_n       = grant;
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      sh        <= '0;
      cnt       <= '0;
      grant     <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      match_cnt <= '0;
      match_any <= 1'b0;
      det_clr   <= 1'b0;
      ser_valid <= 1'b0;
      ser_bit   <= 1'b0;
`ifndef PAT_SCAN_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      sh        <= sh_n;
      cnt       <= cnt_n;
      grant     <= grant_n;
      ack       <= ack_n;
      busy      <= busy_n;
      match_cnt <= match_cnt_n;
      match_any <= match_any_n;
      det_clr   <= det_clr_n;
      ser_valid <= ser_valid_n;
      ser_bit   <= ser_bit_n;
`ifndef PAT_SCAN_FIXED_PRIO_EN
      ptr       <= ptr_n;
`endif
    end
  end
endmodule

// File: tb/tb_pat_scan_arbiter.sv
// Bench for pat_scan_arbiter: behavioural 1011 detector, frame-timeline reference model, directed and random traffic.
module tb_pat_scan_arbiter;
  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]   grant, ack, grant_s, ack_s;
  logic              busy, match_any, det_clr, ser_valid, ser_bit, det_hit;
  logic [CNT_W-1:0]  match_cnt;
  logic              busy_s, match_any_s, det_clr_s, ser_valid_s, ser_bit_s;
  logic [0:0]        match_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pat_scan_arbiter #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .busy(busy), .match_cnt(match_cnt), .match_any(match_any),
    .det_clr(det_clr), .ser_valid(ser_valid), .ser_bit(ser_bit), .det_hit(det_hit)
  );

  // One-bit counter instance fed by the same detector to exercise saturation.
  pat_scan_arbiter #(.NREQ(NREQ), .W(W), .CNT_W(1)) u_sat (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant_s), .ack(ack_s), .busy(busy_s), .match_cnt(match_cnt_s), .match_any(match_any_s),
    .det_clr(det_clr_s), .ser_valid(ser_valid_s), .ser_bit(ser_bit_s), .det_hit(det_hit)
  );

  // Non-overlapping Mealy 1011 detector with registered output, cleared by rst | det_clr.
  int d_st;
  always @(posedge clk) begin
    if (rst || det_clr) begin
      d_st    <= 0;
      det_hit <= 1'b0;
    end else if (ser_valid) begin
      det_hit <= (d_st == 3) && ser_bit;
      case (d_st)
        0:       d_st <= ser_bit ? 1 : 0;
        1:       d_st <= ser_bit ? 1 : 2;
        2:       d_st <= ser_bit ? 3 : 0;
        default: d_st <= ser_bit ? 0 : 2;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef PAT_SCAN_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return 0;
  endfunction

  // Leftmost greedy scan of the word read MSB first.
  function automatic int count_1011(input logic [W-1:0] w);
    int n = 0;
    int i = W - 1;
    while (i >= 3) begin
      if (w[i -: 4] == 4'b1011) begin
        n++;
        i -= 4;
      end else begin
        i--;
      end
    end
    return n;
  endfunction

  // Reference model: phase = cycles since grant appeared, -1 when idle.
  int               phase = -1;
  int               owner = 0;
  int               ptr = 0;
  int               exp_n = 0;
  logic [W-1:0]     word = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_sat = 1'b0;
  logic [NREQ-1:0]  gq[$];

  task automatic post(input int i, input logic [W-1:0] w);
    req[i] = 1'b1;
    req_data[i*W +: W] = w;
  endtask

  task automatic step();
    logic [NREQ-1:0] eg, ea;
    logic ev, eb;
    @(negedge clk);
    // req/rst have been stable since the previous negedge, so they are what the last edge saw.
    if (rst) begin
      phase = -1;
      ptr   = 0;
      m_cnt = '0;
      m_sat = 1'b0;
    end else if (phase < 0) begin
      if (req != '0) begin
        owner = pick(req, ptr);
        ptr   = (owner + 1) % NREQ;
        word  = req_data[owner*W +: W];
        exp_n = count_1011(word);
        phase = 0;
      end
    end else if (phase == W + 2) begin
      phase = -1;
    end else begin
      phase++;
    end
    if (phase == W + 2) begin
      m_cnt = CNT_W'((exp_n > CNT_MAX) ? CNT_MAX : exp_n);
      m_sat = (exp_n != 0);
    end
    eg = (phase >= 0) ? (NREQ'(1) << owner) : '0;
    ea = (phase == W + 2) ? eg : '0;
    ev = (phase >= 1) && (phase <= W);
    eb = ev ? word[W - phase] : 1'b0;
    check("grant", grant, eg);
    check("ack", ack, ea);
    check("busy_clr_valid", {busy, det_clr, ser_valid}, {phase >= 0, phase == 0, ev});
    if (ev || rst) check("ser_bit", ser_bit, eb);
    check("match", {match_any, match_cnt}, {m_cnt != '0, m_cnt});
    check("sat_match", {ack_s, match_cnt_s}, {ea, m_sat});
    if (det_clr) gq.push_back(grant);
    for (int i = 0; i < NREQ; i++) if (ack[i]) req[i] = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int n;
    logic [NREQ-1:0] exp_alt;

    run(3);
    rst = 1'b0;
    run(2);

    post(0, 8'b1011_1011);
    run(14);
    check("tp_bb_cnt", {match_any, match_cnt}, {1'b1, 4'd2});
    post(1, 8'b0101_1011);
    run(13);
    check("tp_5b_cnt", match_cnt, 1);
    post(1, 8'b0000_0000);
    run(13);
    check("tp_zero", {match_any, match_cnt}, 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    gq.delete();
    post(0, 8'b1011_1011);
    post(1, 8'b0101_1011);
    post(2, 8'b1011_0000);
    post(3, 8'b1111_1111);
    run(4 * (W + 4) + 2);
    check("rr_grants", gq.size(), 4);
    for (int k = 0; k < 4; k++) check("rr_order", gq[k], NREQ'(1) << k);
    gq.delete();
    post(3, 8'b0000_1011);
    post(0, 8'b1011_0101);
    run(2 * (W + 4) + 2);
    check("rr_wrap_n", gq.size(), 2);
    check("rr_wrap", gq[0], 4'b0001);

    post(2, 8'b1011_1011);
    n = 0;
    while (!det_clr && n < 20) begin
      step();
      n++;
    end
    check("wait_clr", det_clr, 1);
    run(5);
    rst = 1'b1;
    req[2] = 1'b0;
    step();
    rst = 1'b0;
    check("rst_abort", {busy, grant, ack}, 0);
    post(2, 8'b1011_0000);
    run(W + 5);
    check("rst_next_cnt", match_cnt, 1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    gq.delete();
    post(0, 8'b1011_1011);
    post(2, 8'b0101_1011);
    for (int c = 0; c < 4 * (W + 4) + 2; c++) begin
      step();
      if (!req[0] && !ack[0]) post(0, W'($urandom));
      if (!req[2] && !ack[2]) post(2, W'($urandom));
    end
    check("alt_n", gq.size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
`ifdef PAT_SCAN_FIXED_PRIO_EN
      exp_alt = 4'b0001;
`else
      exp_alt = (k % 2 == 0) ? 4'b0001 : 4'b0100;
`endif
      check("alt_order", gq[k], exp_alt);
    end

    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && !ack[i] && $urandom_range(0, 3) == 0)
          post(i, ($urandom_range(0, 3) == 0) ? W'(32'hBBBB_BBBB) : W'($urandom));
      end
    end
    req = '0;
    run(W + 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pat_scan_arbiter.md
# pat_scan_arbiter

Round-robin controller that shares one serial 1011 sequence detector (non-overlapping Mealy, registered `pat_dec`) among `NREQ` requesters. It accepts a parallel word from the granted requester and clears the detector's state. It then streams the word into the detector one bit per cycle and counts detector hits. Finally it returns the match count to the requester with a one-cycle ack. It sits between the requester bank and the detector instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 8: word width in bits, serialised per frame.
- `CNT_W`, 4: match counter width.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  request per requester; held high until its `ack`.
- `req_data`  in  NREQ*W  word of requester i at `[i*W +: W]`; stable while `req[i]` is high.
- `grant`  out  NREQ  one-hot owner of the current frame; reset 0.
- `ack`  out  NREQ  one-cycle completion pulse to the owner; reset 0.
- `busy`  out  1  high in any state other than IDLE; reset 0.
- `match_cnt`  out  CNT_W  saturating hit count of the last frame; reset 0.
- `match_any`  out  1  `match_cnt != 0`; reset 0.
- `det_clr`  out  1  detector state clear; the detector's reset pin is `rst | det_clr`; reset 0.
- `ser_valid`  out  1  detector `valid`; reset 0.
- `ser_bit`  out  1  detector `data_in`; reset 0.
- `det_hit`  in  1  detector `pat_dec`, registered, updated only on valid cycles.

## Operation
- States: IDLE, CLR, SHIFT, DRAIN, DONE. All outputs are registered.
- IDLE: if any `req` bit is high, select the winner, latch its word into a W-bit shift register, set `grant`, zero the counter, and go to CLR. Otherwise stay in IDLE.
- Round-robin selection: pointer `ptr` resets to 0. The winner is the first asserted `req` at index ≥ `ptr`, wrapping modulo `NREQ`. After granting i, `ptr = (i+1) mod NREQ`.
- CLR: `det_clr=1` for exactly one cycle, then go to SHIFT.
- SHIFT: lasts W cycles with `ser_valid=1`. `ser_bit` is the word MSB first. The bit index counter runs 0..W-1 and moves to DRAIN after bit W-1.
- Hit sampling: `det_hit` is sampled in every cycle whose previous cycle had `ser_valid=1`. That covers SHIFT cycles 2..W plus DRAIN, W samples in total. Each sampled 1 increments the counter, saturating at `2^CNT_W-1`.
- The detector holds `pat_dec` during invalid cycles, so `det_hit` is never sampled outside the windows above.
- DRAIN: `ser_valid=0` for one cycle; take the final sample, then go to DONE.
- DONE: `ack[owner]=1` for one cycle. `match_cnt` and `match_any` update in this cycle and hold until the next DONE. `grant` clears on the exit from DONE. Next state is IDLE.
- `req` changes during a frame are ignored. Only the latched word is used.

## Timing
- Request high at the IDLE sampling edge (cycle T): `grant`/`det_clr` at T+1, bits at T+2..T+W+1, DRAIN at T+W+2, `ack` at T+W+3, IDLE at T+W+4.
- Frame period is W+4 cycles, including one mandatory IDLE cycle between frames.
- A requester drops `req` in the cycle after `ack`. That cycle is IDLE, so it is not re-granted. Re-asserting later is a new request.
- Reset in any state:
  - the next cycle is IDLE with all outputs 0 and `ptr=0`;
  - no `ack` is issued for the aborted frame;
  - the detector is cleared via `rst`.
- Simultaneous requests: exactly one grant per IDLE decision. Others wait and are never dropped.

## Configuration
- `PAT_SCAN_FIXED_PRIO_EN` defined: fixed priority, lowest index wins; `ptr` is not implemented.
- Not defined: round-robin as specified above.

## Test plan
All scenarios use NREQ=4, W=8, CNT_W=4 unless stated.
- `req[0]` with 8'b1011_1011 at T → `grant=4'b0001` at T+1, `ack[0]` at T+11, `match_cnt=2`, `match_any=1`.
- `req[1]` with 8'b0101_1011 → `match_cnt=1` (non-overlapping, not 2). Then 8'b0000_0000 → `match_cnt=0`, `match_any=0`.
- All `req` high with four distinct words, each requester dropping `req` after its `ack` → grants 0, 1, 2, 3 at 12-cycle spacing. Each `match_cnt` matches its own word. Then `req[3]` and `req[0]` together → `req[0]` wins (`ptr` wrapped).
- `rst` for one cycle during SHIFT bit 4 → next cycle `busy=0`, `grant=0`, no `ack`. A following 8'b1011_0000 frame gives `match_cnt=1`, with no residual detector state.
- CNT_W=1 with 8'b1011_1011 → `match_cnt=1` (saturated).
- `PAT_SCAN_FIXED_PRIO_EN`: `req[0]` and `req[2]` both high, `req[0]` re-asserted after each `ack` → `req[0]` granted every frame and `req[2]` waits. Without the macro, grants alternate 0, 2, 0, 2.
